// File: rtl/bus_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_router_pkg
// Description : Shared configuration for the bus router: address map, target
//               indices, FSM state type and an address-range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int unsigned c_num_slaves = 5;

    localparam logic [2:0] c_idx_rom   = 3'd0;
    localparam logic [2:0] c_idx_print = 3'd1;
    localparam logic [2:0] c_idx_clint = 3'd2;
    localparam logic [2:0] c_idx_clic  = 3'd3;
    localparam logic [2:0] c_idx_bram  = 3'd4;

    // Each window is [base, top).
    localparam logic [31:0] c_rom_base_addr   = 32'h0000_0000;
    localparam logic [31:0] c_rom_top_addr    = 32'h0000_4000;
    localparam logic [31:0] c_print_base_addr = 32'h1000_0000;
    localparam logic [31:0] c_print_top_addr  = 32'h1000_0100;
    localparam logic [31:0] c_clint_base_addr = 32'h0200_0000;
    localparam logic [31:0] c_clint_top_addr  = 32'h0201_0000;
    localparam logic [31:0] c_clic_base_addr  = 32'h0C00_0000;
    localparam logic [31:0] c_clic_top_addr   = 32'h0C01_0000;
    localparam logic [31:0] c_bram_base_addr  = 32'h8000_0000;
    localparam logic [31:0] c_bram_top_addr   = 32'h8001_0000;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
        return (addr >= base) && (addr < top);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_router_decode.sv
`default_nettype none
// ============================================================================
// Module      : bus_decode
// Description : Combinational address decoder returning hit flag, target
//               index and target base address.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_decode
    import bus_router_pkg::*;
(
    input  logic [31:0] i_addr,
    input  logic [31:0] i_host_addr,
    output logic        o_hit,
    output logic [2:0]  o_index,
    output logic [31:0] o_base
);

    always_comb begin
        o_hit   = 1'b1;
        o_index = c_idx_bram;
        o_base  = 32'h0;
        // The tohost word lives in bram but is addressed absolutely.
        if (i_addr == i_host_addr) begin
            o_index = c_idx_bram;
            o_base  = 32'h0;
        end else if (in_range(i_addr, c_bram_base_addr, c_bram_top_addr)) begin
            o_index = c_idx_bram;
            o_base  = c_bram_base_addr;
        end else if (in_range(i_addr, c_clic_base_addr, c_clic_top_addr)) begin
            o_index = c_idx_clic;
            o_base  = c_clic_base_addr;
        end else if (in_range(i_addr, c_clint_base_addr, c_clint_top_addr)) begin
            o_index = c_idx_clint;
            o_base  = c_clint_base_addr;
        end else if (in_range(i_addr, c_print_base_addr, c_print_top_addr)) begin
            o_index = c_idx_print;
            o_base  = c_print_base_addr;
        end else if (in_range(i_addr, c_rom_base_addr, c_rom_top_addr)) begin
            o_index = c_idx_rom;
            o_base  = c_rom_base_addr;
        end else begin
            o_hit   = 1'b0;
            o_index = c_idx_rom;
            o_base  = 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_router.sv
`default_nettype none
// ============================================================================
// Module      : bus_router
// Description : Single-outstanding request router from one memory port to
//               five slaves, with decode-miss and timeout error replies.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_router
    import bus_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      memory_valid,
    input  logic                      memory_instr,
    input  logic [31:0]               memory_addr,
    input  logic [31:0]               memory_wdata,
    input  logic [3:0]                memory_wstrb,
    output logic [31:0]               memory_rdata,
    output logic                      memory_error,
    output logic                      memory_ready,
    input  logic [31:0]               host_addr,
    output logic [c_num_slaves-1:0]   slv_valid,
    output logic                      slv_instr,
    output logic [31:0]               slv_addr,
    output logic [31:0]               slv_wdata,
    output logic [3:0]                slv_wstrb,
    input  logic [32*c_num_slaves-1:0] slv_rdata,
    input  logic [c_num_slaves-1:0]   slv_ready,
    output logic                      proto_err
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT);

    state_t                  r_state;
    logic [2:0]              r_sel;
    logic [15:0]             r_count;
    logic                    r_miss_hold;
    logic [c_num_slaves-1:0] r_slv_valid;
    logic                    r_slv_instr;
    logic [31:0]             r_slv_addr;
    logic [31:0]             r_slv_wdata;
    logic [3:0]              r_slv_wstrb;
    logic                    r_memory_ready;
    logic                    r_memory_error;
    logic [31:0]             r_memory_rdata;
    logic                    r_proto_err;

    logic                    w_hit;
    logic [2:0]              w_index;
    logic [31:0]             w_base;
    logic [c_num_slaves-1:0] w_onehot;
    logic                    w_sel_ready;
    logic [31:0]             w_sel_rdata;
    logic [31:0]             w_rdata_arr [c_num_slaves];

    bus_decode u_decode (
        .i_addr      (memory_addr),
        .i_host_addr (host_addr),
        .o_hit       (w_hit),
        .o_index     (w_index),
        .o_base      (w_base)
    );

    for (genvar g = 0; g < c_num_slaves; g++) begin : g_rdata_split
        assign w_rdata_arr[g] = slv_rdata[32*g +: 32];
    end

    assign w_onehot    = c_num_slaves'(1) << w_index;
    assign w_sel_ready = slv_ready[r_sel];
    assign w_sel_rdata = w_rdata_arr[r_sel];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_sel          <= '0;
            r_count        <= '0;
            r_miss_hold    <= 1'b0;
            r_slv_valid    <= '0;
            r_slv_instr    <= 1'b0;
            r_slv_addr     <= '0;
            r_slv_wdata    <= '0;
            r_slv_wstrb    <= '0;
            r_memory_ready <= 1'b0;
            r_memory_error <= 1'b0;
            r_memory_rdata <= '0;
            r_proto_err    <= 1'b0;
        end else begin
            r_slv_valid <= '0;
            if (memory_valid && (r_state != ST_IDLE)) begin
                r_proto_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (memory_valid) begin
                        r_slv_instr <= memory_instr;
                        r_slv_wdata <= memory_wdata;
                        r_slv_wstrb <= memory_wstrb;
                        r_slv_addr  <= memory_addr - w_base;
                        r_sel       <= w_index;
                        r_count     <= '0;
                        if (w_hit) begin
                            r_slv_valid <= w_onehot;
                            r_state     <= ST_ISSUE;
                        end else begin
                            r_miss_hold <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A ready that coincides with expiry still wins.
                    if (w_sel_ready) begin
                        r_memory_ready <= 1'b1;
                        r_memory_error <= 1'b0;
                        r_memory_rdata <= w_sel_rdata;
                        r_state        <= ST_RESP;
                    end else if (r_count == c_timeout) begin
                        r_memory_ready <= 1'b1;
                        r_memory_error <= 1'b1;
                        r_memory_rdata <= '0;
                        r_state        <= ST_RESP;
                    end else begin
                        r_count <= r_count + 16'd1;
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    // A decode miss lingers one cycle so it answers with hit latency.
                    if (r_miss_hold) begin
                        r_miss_hold    <= 1'b0;
                        r_memory_ready <= 1'b1;
                        r_memory_error <= 1'b1;
                        r_memory_rdata <= '0;
                    end else begin
                        r_memory_ready <= 1'b0;
                        r_memory_error <= 1'b0;
                        r_memory_rdata <= '0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign slv_valid    = r_slv_valid;
    assign slv_instr    = r_slv_instr;
    assign slv_addr     = r_slv_addr;
    assign slv_wdata    = r_slv_wdata;
    assign slv_wstrb    = r_slv_wstrb;
    assign memory_ready = r_memory_ready;
    assign memory_error = r_memory_error;
    assign memory_rdata = r_memory_rdata;
    assign proto_err    = r_proto_err;

endmodule
`default_nettype wire

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning slave-response cycles allowed before an error reply (legal range 2..65535).
REQ-002 SHALL have ports: reset input 1, synchronous active-high reset; clock input 1, sole clock, all state updates on its rising edge.
REQ-003 SHALL have ports: memory_valid input 1 request strobe; memory_instr input 1 fetch flag; memory_addr input 32; memory_wdata input 32; memory_wstrb input 4, 0 means read.
REQ-004 SHALL have ports: memory_rdata output 32; memory_error output 1; memory_ready output 1, one-cycle response strobe.
REQ-005 SHALL have ports: host_addr input 32, tohost address that always routes to bram.
REQ-006 SHALL have ports: slv_valid output 5, one-hot request pulse, bit order rom=0, print=1, clint=2, clic=3, bram=4; slv_instr output 1; slv_addr output 32, target-relative offset; slv_wdata output 32; slv_wstrb output 4.
REQ-007 SHALL have ports: slv_rdata input 160, 32 bits per target in bit order; slv_ready input 5.
REQ-008 SHALL have ports: proto_err output 1, sticky flag for requester protocol violation.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-010 SHALL accept a request only in IDLE with memory_valid=1, registering instr, wdata, wstrb, target index and offset=memory_addr-base.
REQ-011 SHALL decode in priority order: addr==host_addr -> bram with base 0, then bram, clic, clint, print, rom ranges [base,top), using package constants.
REQ-012 SHALL, on decode miss, go IDLE->RESP with memory_error=1 and rdata=0, giving memory_ready exactly 2 cycles after acceptance.
REQ-013 SHALL, on decode hit, go IDLE->ISSUE and drive slv_valid[sel]=1 for exactly one cycle in ISSUE, then enter WAIT.
REQ-014 SHALL hold slv_instr/addr/wdata/wstrb stable from ISSUE until leaving WAIT.
REQ-015 SHALL, in ISSUE or WAIT, on slv_ready[sel]=1, capture slv_rdata[sel] and go to RESP; a ready from a zero-latency slave during ISSUE SHALL count.
REQ-016 SHALL ignore slv_ready bits of non-selected targets, and any slave ready arriving outside ISSUE/WAIT.
REQ-017 SHALL drive memory_ready=1 for exactly one cycle in RESP with the captured rdata and error, then return to IDLE; rdata SHALL be 0 whenever memory_ready=0.
REQ-018 SHALL count cycles spent in ISSUE+WAIT with a 16-bit counter; on reaching TIMEOUT without ready it SHALL go to RESP with memory_error=1 and rdata=0.
REQ-019 SHALL treat slave ready and the timeout occurring in the same cycle as a successful ready.
REQ-020 SHALL set proto_err when memory_valid=1 in any state other than IDLE; such requests SHALL be dropped, and proto_err SHALL clear only on reset.
REQ-021 SHALL give minimum hit latency as: acceptance at T, slv_valid at T+1, memory_ready at T+2 when the slave answers at T+1.
REQ-022 SHALL accept a new request in the IDLE cycle immediately after RESP, giving back-to-back throughput of one request per 3 cycles minimum.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, go to IDLE and clear the counter, proto_err and captured data; memory_ready, memory_error, memory_rdata and slv_valid SHALL then be 0.
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation with no response, and SHALL not accept a request in a cycle where reset=1.

Structure
REQ-025 SHALL take rom/print/clint/clic/bram base and top addresses, target index constants, and the state enum typedef from the shared configure package.
REQ-026 SHALL contain one sub-module, bus_decode, which is combinational and maps addr and host_addr to hit, index and base.

Verification
REQ-027 Read of bram_base_addr+0x10 with bram ready at first ISSUE cycle and rdata 0xDEADBEEF -> slv_valid=5'b10000 for 1 cycle, slv_addr=0x10, memory_ready at T+2 with rdata 0xDEADBEEF and error 0.
REQ-028 Write 0x41 with wstrb=4'b0001 to host_addr -> bram selected, slv_addr=host_addr, slv_wstrb=4'b0001, a single response.
REQ-029 Access to an unmapped address -> no slv_valid, memory_ready+memory_error at T+2, rdata=0.
REQ-030 Clint never answers, TIMEOUT=8 -> memory_error response at T+10, and a late clint ready is ignored.
REQ-031 memory_valid asserted during WAIT, plus a stray print ready while clic is selected -> proto_err=1, the second request is never issued, and the clic response is unaffected.
REQ-032 reset=1 while in WAIT -> next cycle IDLE, all outputs 0, no memory_ready, and a new request is served normally afterwards.
